// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl - hazard and sequencing controller for a 5-stage RISC-V pipeline.
//
// Drives stall/flush for the IF/ID (fd), ID/EX (de), EX/MEM (em) and MEM/WB (mw)
// pipeline registers, generates EX-stage forwarding selects, freezes the pipe
// while a multi-cycle data-memory access is outstanding and traps hung accesses.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   rs1_D, rs2_D             decode-stage source registers
//   rs1_E, rs2_E, rd_E       execute-stage sources / destination
//   mem_rd_E                 execute-stage instruction is a load
//   rd_M, reg_wr_M           memory-stage destination / write enable
//   mem_req_M, mem_ready_M   memory-stage data access request / completion
//   rd_W, reg_wr_W           writeback-stage destination / write enable
//   branch_taken_E           execute-stage branch/jump resolved taken
//   stall_*, flush_*         per-register hold / clear
//   redirect_F               fetch takes the branch target
//   fwd_a_E, fwd_b_E         00 = regfile, 01 = writeback, 10 = memory-stage ALU result
//   mem_err                  sticky memory-timeout error
//   state_o                  current FSM state (debug)
//
// Optional feature macro: HAZARD_PERF_EN adds 32-bit wrapping counters
//   perf_lu_stalls (load-use bubbles), perf_mem_wait (MEM_WAIT cycles),
//   perf_flushes (taken-branch redirects).
//
// State table:
//   state    | meaning
//   RUN      | normal flow; branch / load-use handling
//   MEM_WAIT | data access outstanding, pipe frozen, wait counter running
//   ERROR    | access timed out; whole pipe held until reset

module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs1_D,
    input  logic [4:0] rs2_D,
    input  logic [4:0] rs1_E,
    input  logic [4:0] rs2_E,
    input  logic [4:0] rd_E,
    input  logic       mem_rd_E,
    input  logic [4:0] rd_M,
    input  logic       reg_wr_M,
    input  logic       mem_req_M,
    input  logic       mem_ready_M,
    input  logic [4:0] rd_W,
    input  logic       reg_wr_W,
    input  logic       branch_taken_E,
    output logic       stall_fd,
    output logic       stall_de,
    output logic       stall_em,
    output logic       stall_mw,
    output logic       flush_fd,
    output logic       flush_de,
    output logic       flush_em,
    output logic       flush_mw,
    output logic       redirect_F,
    output logic [1:0] fwd_a_E,
    output logic [1:0] fwd_b_E,
    output logic       mem_err,
    output logic [1:0] state_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] perf_lu_stalls,
    output logic [31:0] perf_mem_wait,
    output logic [31:0] perf_flushes
`endif
);

    localparam logic [1:0] RUN      = 2'b00;
    localparam logic [1:0] MEM_WAIT = 2'b01;
    localparam logic [1:0] ERROR    = 2'b10;

    logic [1:0]       state;
    logic [CNT_W-1:0] wait_cnt;
    logic             wait_cond;
    logic             load_use;
    logic             lu_bubble;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (reg_wr_M && rd_M != 5'd0 && rd_M == rs)
            return 2'b10;
        else if (reg_wr_W && rd_W != 5'd0 && rd_W == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    // While waiting, only completion matters; the request is assumed held.
    assign wait_cond = (state == RUN)      ? (mem_req_M && !mem_ready_M) :
                       (state == MEM_WAIT) ? !mem_ready_M : 1'b0;
    assign load_use  = mem_rd_E && rd_E != 5'd0 && (rd_E == rs1_D || rd_E == rs2_D);
    assign state_o   = state;

    always_comb begin
        stall_fd   = 1'b0;
        stall_de   = 1'b0;
        stall_em   = 1'b0;
        stall_mw   = 1'b0;
        flush_fd   = 1'b0;
        flush_de   = 1'b0;
        flush_em   = 1'b0;
        flush_mw   = 1'b0;
        redirect_F = 1'b0;
        lu_bubble  = 1'b0;
        fwd_a_E    = 2'b00;
        fwd_b_E    = 2'b00;
        if (!rst) begin
            fwd_a_E = fwd_sel(rs1_E);
            fwd_b_E = fwd_sel(rs2_E);
            if (state == ERROR) begin
                stall_fd = 1'b1;
                stall_de = 1'b1;
                stall_em = 1'b1;
                stall_mw = 1'b1;
            end else if (wait_cond) begin
                // Branch in EX is held and re-evaluated when the access completes.
                stall_fd = 1'b1;
                stall_de = 1'b1;
                stall_em = 1'b1;
                flush_mw = 1'b1;
            end else if (branch_taken_E) begin
                redirect_F = 1'b1;
                flush_fd   = 1'b1;
                flush_de   = 1'b1;
            end else if (load_use) begin
                stall_fd  = 1'b1;
                flush_de  = 1'b1;
                lu_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_req_M && !mem_ready_M) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= CNT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready_M) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == CNT_W'(MEM_TIMEOUT)) begin
                        state   <= ERROR;
                        mem_err <= 1'b1;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ERROR:   state <= ERROR;
                default: state <= RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_lu_stalls <= '0;
            perf_mem_wait  <= '0;
            perf_flushes   <= '0;
        end else begin
            if (lu_bubble)
                perf_lu_stalls <= perf_lu_stalls + 32'd1;
            if (state == MEM_WAIT)
                perf_mem_wait <= perf_mem_wait + 32'd1;
            if (redirect_F)
                perf_flushes <= perf_flushes + 32'd1;
        end
    end
`else
    logic unused_lu;
    assign unused_lu = lu_bubble;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
    logic       mem_rd_E, reg_wr_M, mem_req_M, mem_ready_M, reg_wr_W, branch_taken_E;
    logic       stall_fd, stall_de, stall_em, stall_mw;
    logic       flush_fd, flush_de, flush_em, flush_mw;
    logic       redirect_F, mem_err;
    logic [1:0] fwd_a_E, fwd_b_E, state_o;

    int checks   = 0;
    int failures = 0;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
        .mem_rd_E(mem_rd_E), .rd_M(rd_M), .reg_wr_M(reg_wr_M),
        .mem_req_M(mem_req_M), .mem_ready_M(mem_ready_M),
        .rd_W(rd_W), .reg_wr_W(reg_wr_W), .branch_taken_E(branch_taken_E),
        .stall_fd(stall_fd), .stall_de(stall_de), .stall_em(stall_em), .stall_mw(stall_mw),
        .flush_fd(flush_fd), .flush_de(flush_de), .flush_em(flush_em), .flush_mw(flush_mw),
        .redirect_F(redirect_F), .fwd_a_E(fwd_a_E), .fwd_b_E(fwd_b_E),
        .mem_err(mem_err), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_pending: how many cycles the current data access has already been
    // outstanding (0 = none); m_err: the access ran out of time.
    int m_pending;
    bit m_err;

    function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
        if (reg_wr_M && rd_M != 0 && rd_M == rs) return 2'b10;
        if (reg_wr_W && rd_W != 0 && rd_W == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit waiting_now();
        if (m_pending > 0) return !mem_ready_M;
        return mem_req_M && !mem_ready_M;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pending <= 0;
            m_err     <= 1'b0;
        end else if (!m_err) begin
            if (waiting_now()) begin
                if (m_pending == TO) m_err <= 1'b1;
                else                 m_pending <= m_pending + 1;
            end else begin
                m_pending <= 0;
            end
        end
    end

    logic [3:0] e_st, e_fl;
    logic       e_redir;
    logic [1:0] e_state;

    always @(negedge clk) begin
        e_st = 4'b0; e_fl = 4'b0; e_redir = 1'b0;
        e_state = m_err ? 2'b10 : (m_pending > 0) ? 2'b01 : 2'b00;
        if (!rst) begin
            if (m_err) e_st = 4'b1111;
            else if (waiting_now()) begin
                e_st = 4'b1110; e_fl = 4'b0001;
            end else if (branch_taken_E) begin
                e_redir = 1'b1; e_fl = 4'b1100;
            end else if (mem_rd_E && rd_E != 0 && (rd_E == rs1_D || rd_E == rs2_D)) begin
                e_st = 4'b1000; e_fl = 4'b0100;
            end
        end
        chk("stalls",   {stall_fd, stall_de, stall_em, stall_mw}, e_st);
        chk("flushes",  {flush_fd, flush_de, flush_em, flush_mw}, e_fl);
        chk("redirect", redirect_F, e_redir);
        chk("fwd_a",    fwd_a_E, rst ? 2'b00 : exp_fwd(rs1_E));
        chk("fwd_b",    fwd_b_E, rst ? 2'b00 : exp_fwd(rs2_E));
        chk("state",    state_o, e_state);
        chk("mem_err",  mem_err, m_err);
        chk("no_stall_and_flush",
            {stall_fd, stall_de, stall_em, stall_mw} & {flush_fd, flush_de, flush_em, flush_mw}, 4'b0);
    end

    // ---------------- directed stimulus ----------------
    task automatic clear_inputs();
        rs1_D = 0; rs2_D = 0; rs1_E = 0; rs2_E = 0; rd_E = 0; rd_M = 0; rd_W = 0;
        mem_rd_E = 0; reg_wr_M = 0; mem_req_M = 0; mem_ready_M = 0;
        reg_wr_W = 0; branch_taken_E = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic at_sample();
        @(negedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        // Reset gating: conditions that would otherwise stall/redirect.
        mem_req_M = 1; branch_taken_E = 1; reg_wr_M = 1; rd_M = 3; rs1_E = 3;
        at_sample();
        chk("rst_stall_fd", stall_fd, 1'b0);
        chk("rst_redirect", redirect_F, 1'b0);
        chk("rst_fwd_a", fwd_a_E, 2'b00);
        chk("rst_state", state_o, 2'b00);
        clear_inputs();
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // 1: load-use then forward from memory stage
        mem_rd_E = 1; rd_E = 5; rs1_D = 5;
        at_sample();
        chk("lu_stall_fd", stall_fd, 1'b1);
        chk("lu_flush_de", flush_de, 1'b1);
        chk("lu_stall_de", stall_de, 1'b0);
        next_cycle();
        mem_rd_E = 0; rd_E = 0; rs1_D = 0; reg_wr_M = 1; rd_M = 5; rs1_E = 5;
        at_sample();
        chk("lu_after_stall_fd", stall_fd, 1'b0);
        chk("lu_fwd_a", fwd_a_E, 2'b10);
        next_cycle();

        // 2: forwarding priority and x0
        clear_inputs();
        reg_wr_M = 1; reg_wr_W = 1; rd_M = 7; rd_W = 7; rs2_E = 7;
        at_sample();
        chk("fwd_b_mem_wins", fwd_b_E, 2'b10);
        next_cycle();
        reg_wr_M = 0;
        at_sample();
        chk("fwd_b_wb", fwd_b_E, 2'b01);
        next_cycle();
        reg_wr_M = 1; rd_M = 0; rd_W = 0; rs2_E = 0;
        at_sample();
        chk("fwd_b_x0", fwd_b_E, 2'b00);
        next_cycle();

        // 3: 3-cycle memory wait
        clear_inputs();
        mem_req_M = 1;
        for (int i = 0; i < 3; i++) begin
            at_sample();
            chk("mw_stall_em", stall_em, 1'b1);
            chk("mw_flush_mw", flush_mw, 1'b1);
            chk("mw_state", state_o, (i == 0) ? 2'b00 : 2'b01);
            next_cycle();
        end
        mem_ready_M = 1;
        at_sample();
        chk("mw_ready_stall_fd", stall_fd, 1'b0);
        chk("mw_ready_state", state_o, 2'b01);
        next_cycle();
        clear_inputs();
        at_sample();
        chk("mw_back_run", state_o, 2'b00);
        next_cycle();

        // 4: branch held during a 2-cycle wait
        mem_req_M = 1; branch_taken_E = 1;
        for (int i = 0; i < 2; i++) begin
            at_sample();
            chk("br_wait_redirect", redirect_F, 1'b0);
            chk("br_wait_flush_fd", flush_fd, 1'b0);
            next_cycle();
        end
        mem_ready_M = 1;
        at_sample();
        chk("br_exit_redirect", redirect_F, 1'b1);
        chk("br_exit_flush_fd", flush_fd, 1'b1);
        chk("br_exit_flush_de", flush_de, 1'b1);
        next_cycle();
        clear_inputs();

        // 5: branch beats load-use; load-use via rs2; rd_E=x0 is no hazard
        branch_taken_E = 1; mem_rd_E = 1; rd_E = 3; rs2_D = 3;
        at_sample();
        chk("br_lu_redirect", redirect_F, 1'b1);
        chk("br_lu_stall_fd", stall_fd, 1'b0);
        chk("br_lu_flush_de", flush_de, 1'b1);
        next_cycle();
        branch_taken_E = 0;
        at_sample();
        chk("lu_rs2_stall_fd", stall_fd, 1'b1);
        next_cycle();
        rd_E = 0; rs2_D = 0;
        at_sample();
        chk("lu_x0_stall_fd", stall_fd, 1'b0);
        next_cycle();
        clear_inputs();

        // 6: timeout -> ERROR, then async reset
        mem_req_M = 1;
        for (int i = 0; i < TO + 1; i++) begin
            at_sample();
            chk("to_no_err_yet", mem_err, 1'b0);
            next_cycle();
        end
        at_sample();
        chk("to_mem_err", mem_err, 1'b1);
        chk("to_state", state_o, 2'b10);
        chk("to_all_stalls", {stall_fd, stall_de, stall_em, stall_mw}, 4'b1111);
        chk("to_no_flush", {flush_fd, flush_de, flush_em, flush_mw}, 4'b0000);
        next_cycle();
        mem_ready_M = 1;
        at_sample();
        chk("err_sticky_state", state_o, 2'b10);
        rst = 1'b1;
        #1;
        chk("async_rst_err", mem_err, 1'b0);
        chk("async_rst_state", state_o, 2'b00);
        chk("async_rst_stall", stall_mw, 1'b0);
        next_cycle();
        clear_inputs();
        rst = 1'b0;
        next_cycle();
        at_sample();
        chk("post_rst_state", state_o, 2'b00);
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central hazard/sequencing controller for the 5-stage RISC-V pipeline. Drives the stall/flush pair of every pipeline register: IF/ID (fd), ID/EX (de), EX/MEM (em), MEM/WB (mw).
- Generates EX-stage forwarding selects.
- Freezes the pipeline while a multi-cycle data-memory access is outstanding.
- Times out hung memory accesses.
- Pipeline registers give stall priority over flush; this block never asserts stall and flush on the same register in the same cycle.

Parameters:
MEM_TIMEOUT, 64, cycles in MEM_WAIT before declaring a memory error (>=2)
CNT_W, 8, width of the memory-wait cycle counter (2^CNT_W > MEM_TIMEOUT)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
rs1_D, rs2_D  in  5  source registers of instruction in decode
rs1_E, rs2_E  in  5  source registers of instruction in execute
rd_E  in  5  destination register in execute
mem_rd_E  in  1  instruction in execute is a load
rd_M  in  5  destination register in memory stage
reg_wr_M  in  1  memory-stage instruction writes rd_M
mem_req_M  in  1  memory-stage instruction accesses data memory (load or store)
mem_ready_M  in  1  data memory completes the access this cycle
rd_W  in  5  destination register in writeback
reg_wr_W  in  1  writeback-stage instruction writes rd_W
branch_taken_E  in  1  branch/jump in execute resolves taken
stall_fd, stall_de, stall_em, stall_mw  out  1 each  hold the named pipeline register
flush_fd, flush_de, flush_em, flush_mw  out  1 each  clear the named pipeline register
redirect_F  out  1  fetch takes the branch target this cycle
fwd_a_E, fwd_b_E  out  2 each  operand select: 00 = register file, 01 = writeback, 10 = memory-stage ALU result
mem_err  out  1  sticky memory-timeout error
state_o  out  2  current FSM state, for debug

Behaviour:
Reset:
- rst is asynchronous active-high. It forces state RUN, wait counter 0, mem_err 0.
- While rst is high, all stall/flush/redirect outputs are 0 and fwd selects are 00.

Forwarding (combinational, every state):
- fwd_a_E = 10 if reg_wr_M && rd_M!=0 && rd_M==rs1_E.
- Otherwise 01 if reg_wr_W && rd_W!=0 && rd_W==rs1_E.
- Otherwise 00.
- The memory stage wins when both match. fwd_b_E is identical, using rs2_E.

FSM states: RUN=00, MEM_WAIT=01, ERROR=10.

RUN, evaluated in priority order:
1. mem_req_M && !mem_ready_M:
   - stall_fd, stall_de, stall_em = 1; flush_mw = 1 (bubble into WB).
   - Go to MEM_WAIT; counter <= 1.
   - Any branch_taken_E this cycle is ignored: redirect_F=0, no flush. The branch stays held in EX and is re-evaluated on exit.
2. branch_taken_E:
   - redirect_F=1, flush_fd=1, flush_de=1.
   - No load-use stall, even when one is also detected.
3. Load-use (mem_rd_E && rd_E!=0 && (rd_E==rs1_D || rd_E==rs2_D)):
   - stall_fd=1, stall_de=0, flush_de=1. One bubble; the stall lasts exactly 1 cycle.
4. Otherwise: all outputs 0.

A single-cycle access (mem_ready_M=1 in the first cycle) produces no stall.

MEM_WAIT:
- Outputs are the same as case 1 of RUN.
- Counter increments every cycle, saturating at its maximum.
- mem_ready_M=1: the exit cycle behaves exactly as RUN with the wait condition false. Stalls drop, a pending branch redirects/flushes, and the FSM returns to RUN with counter <= 0.
- counter==MEM_TIMEOUT && !mem_ready_M: go to ERROR; mem_err <= 1.

ERROR:
- stall_fd, stall_de, stall_em, stall_mw = 1; all flush outputs 0; redirect_F=0.
- Left only by rst.

Never: stall_X && flush_X for the same register. flush_em is always 0 in this revision.

Optional Feature:
HAZARD_PERF_EN.
- Defined: adds outputs perf_lu_stalls, perf_mem_wait, perf_flushes (32 bits each). They count load-use bubbles, MEM_WAIT cycles and taken-branch redirects respectively. Counters wrap at 2^32 and are cleared by rst.
- Undefined: these ports are absent and no counter logic is built.

Test Plan:
1. Load x5 in EX (mem_rd_E=1, rd_E=5) with rs1_D=5 -> exactly 1 cycle of stall_fd=1, flush_de=1. Next cycle, with reg_wr_M=1, rd_M=5, rs1_E=5 -> fwd_a_E=10.
2. rd_M=rd_W=7, both reg_wr=1, rs2_E=7 -> fwd_b_E=10. Then rd_M=0 with rs2_E=0 -> 00.
3. mem_req_M=1, mem_ready_M low for 3 cycles then high -> stall_fd/de/em and flush_mw high for 3 cycles, state_o=01. They drop on the ready cycle; state_o=00 next cycle.
4. branch_taken_E=1 during a 2-cycle memory wait -> redirect_F=0 while waiting. On the ready cycle: redirect_F=1, flush_fd=1, flush_de=1.
5. Branch taken and load-use hazard in the same cycle -> redirect_F=1, flush_fd=1, flush_de=1, stall_fd=0.
6. MEM_TIMEOUT=4, mem_ready_M held low -> mem_err=1 after the counter reaches 4, state_o=10, all four stalls 1. Asserting rst mid-ERROR clears mem_err and returns state_o to 00 immediately (asynchronously).
